// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller for the one-bit `full` cell.
// Streams operands LSB-first and rebuilds the parallel sum.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             ovf_out
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [7:0] LAST = 8'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_out_q, sum_out_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_shift;

    // A one-bit result has no older bits to carry along.
    if (WIDTH == 1) begin : g_w1
        assign sum_shift = fa_sum;
    end else begin : g_wn
        assign sum_shift = {fa_sum, sum_sr_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        sum_sr_d  = sum_sr_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        sum_out_d = sum_out_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d   = a_in;
                    b_sr_d   = b_in;
                    carry_d  = cin_in;
                    cnt_d    = '0;
                    sum_sr_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                sum_sr_d = sum_shift;
                carry_d  = fa_cout;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                cnt_d    = cnt_q + 8'd1;
                if (cnt_q == LAST) begin
                    sum_out_d = sum_shift;
                    cout_d    = fa_cout;
                    // carry into the MSB differs from carry out of it
                    ovf_d     = carry_q ^ fa_cout;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            sum_sr_q  <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            sum_out_q <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            sum_sr_q  <= sum_sr_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            sum_out_q <= sum_out_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign fa_a     = a_sr_q[0];
    assign fa_b     = b_sr_q[0];
    assign fa_cin   = carry_q;
    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign sum_out  = sum_out_q;
    assign cout_out = cout_q;
    assign ovf_out  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances,
// each driving a behavioural full-adder cell.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       s8, c8;
    logic [7:0] a8, b8;
    logic       fa_a8, fa_b8, fa_cin8, fs8, fc8;
    logic       busy8, done8, co8, ov8;
    logic [7:0] sum8;

    logic       s1, c1;
    logic [0:0] a1, b1;
    logic       fa_a1, fa_b1, fa_cin1, fs1, fc1;
    logic       busy1, done1, co1, ov1;
    logic [0:0] sum1;

    assign fs8 = fa_a8 ^ fa_b8 ^ fa_cin8;
    assign fc8 = (fa_a8 & fa_b8) | (fa_cin8 & (fa_a8 ^ fa_b8));
    assign fs1 = fa_a1 ^ fa_b1 ^ fa_cin1;
    assign fc1 = (fa_a1 & fa_b1) | (fa_cin1 & (fa_a1 ^ fa_b1));

    serial_add_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(s8),
        .a_in(a8), .b_in(b8), .cin_in(c8),
        .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8),
        .fa_sum(fs8), .fa_cout(fc8),
        .busy(busy8), .done(done8), .sum_out(sum8),
        .cout_out(co8), .ovf_out(ov8)
    );

    serial_add_ctrl #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(s1),
        .a_in(a1), .b_in(b1), .cin_in(c1),
        .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1),
        .fa_sum(fs1), .fa_cout(fc1),
        .busy(busy1), .done(done1), .sum_out(sum1),
        .cout_out(co1), .ovf_out(ov1)
    );

    int ncmp  = 0;
    int nfail = 0;

    logic [7:0] p8_s;
    logic       p8_c, p8_o;
    logic [0:0] p1_s;
    logic       p1_c, p1_o;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer add, signed overflow from operand/result signs.
    task automatic refadd(input int w, input int a, input int b,
                          input int c, output int s, output int co,
                          output int ov);
        int t, sa, sb, ss;
        t  = a + b + c;
        s  = t & ((1 << w) - 1);
        co = (t >> w) & 1;
        sa = (a >> (w - 1)) & 1;
        sb = (b >> (w - 1)) & 1;
        ss = (s >> (w - 1)) & 1;
        ov = (sa == sb && ss != sa) ? 1 : 0;
    endtask

    task automatic add8(input logic [7:0] a, input logic [7:0] b,
                        input logic c, input int glitch);
        int es, ec, eo;
        refadd(8, int'(a), int'(b), int'(c), es, ec, eo);
        @(negedge clk);
        a8 = a; b8 = b; c8 = c; s8 = 1'b1;
        @(posedge clk); #1;
        s8 = 1'b0; a8 = ~a; b8 = ~b; c8 = ~c;
        for (int k = 0; k < 8; k++) begin
            chk("busy8", 32'(busy8), 32'd1);
            chk("done8_early", 32'(done8), 32'd0);
            chk("hold8_sum", 32'(sum8), 32'(p8_s));
            chk("hold8_flags", {30'd0, co8, ov8}, {30'd0, p8_c, p8_o});
            if (k == glitch) begin
                s8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
            end else begin
                s8 = 1'b0;
            end
            @(posedge clk); #1;
        end
        s8 = 1'b0;
        chk("done8", 32'(done8), 32'd1);
        chk("idle8", 32'(busy8), 32'd0);
        chk("sum8", 32'(sum8), 32'(es));
        chk("cout8", 32'(co8), 32'(ec));
        chk("ovf8", 32'(ov8), 32'(eo));
        p8_s = sum8; p8_c = co8; p8_o = ov8;
        @(posedge clk); #1;
        chk("done8_fall", 32'(done8), 32'd0);
        chk("idle8_after", 32'(busy8), 32'd0);
    endtask

    task automatic add1(input logic a, input logic b, input logic c);
        int es, ec, eo;
        refadd(1, int'(a), int'(b), int'(c), es, ec, eo);
        @(negedge clk);
        a1 = a; b1 = b; c1 = c; s1 = 1'b1;
        @(posedge clk); #1;
        s1 = 1'b0; a1 = ~a; b1 = ~b; c1 = ~c;
        chk("busy1", 32'(busy1), 32'd1);
        chk("done1_early", 32'(done1), 32'd0);
        chk("hold1", {29'd0, sum1, co1, ov1}, {29'd0, p1_s, p1_c, p1_o});
        @(posedge clk); #1;
        chk("done1", 32'(done1), 32'd1);
        chk("idle1", 32'(busy1), 32'd0);
        chk("sum1", 32'(sum1), 32'(es));
        chk("cout1", 32'(co1), 32'(ec));
        chk("ovf1", 32'(ov1), 32'(eo));
        p1_s = sum1; p1_c = co1; p1_o = ov1;
    endtask

    task automatic wait_done8(output int cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done8) break;
        end
    endtask

    initial begin
        int t1, t2, pulses;
        rst_n = 1'b0;
        s8 = 0; a8 = 0; b8 = 0; c8 = 0;
        s1 = 0; a1 = 0; b1 = 0; c1 = 0;
        p8_s = 0; p8_c = 0; p8_o = 0;
        p1_s = 0; p1_c = 0; p1_o = 0;
        #12;
        chk("rst_out8", {21'd0, busy8, done8, sum8, co8, ov8}, 32'd0);
        chk("rst_fa8", {29'd0, fa_a8, fa_b8, fa_cin8}, 32'd0);
        chk("rst_out1", {27'd0, busy1, done1, sum1, co1, ov1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        add8(8'h5A, 8'h3C, 1'b0, -1);
        add8(8'hFF, 8'h01, 1'b0, -1);
        add8(8'hFF, 8'h00, 1'b1, -1);
        add8(8'h7F, 8'h01, 1'b0, -1);
        add8(8'h80, 8'h80, 1'b0, -1);
        add8(8'h11, 8'h22, 1'b0, 3);
        chk("ignored_start", 32'(busy8), 32'd0);

        // start held high across the done cycle
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; s8 = 1'b1;
        @(posedge clk); #1;
        wait_done8(t1);
        chk("b2b_lat", 32'(t1), 32'd8);
        chk("b2b_sum1", 32'(sum8), 32'h46);
        a8 = 8'h55; b8 = 8'h66;
        wait_done8(t2);
        s8 = 1'b0;
        chk("b2b_gap", 32'(t2), 32'd9);
        chk("b2b_sum2", 32'(sum8), 32'hBB);
        chk("b2b_ovf2", 32'(ov8), 32'd1);
        @(posedge clk); #1;

        // asynchronous reset in the middle of an add
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h44; c8 = 1'b1; s8 = 1'b1;
        @(posedge clk); #1;
        s8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out", {21'd0, busy8, done8, sum8, co8, ov8}, 32'd0);
        chk("arst_fa", {29'd0, fa_a8, fa_b8, fa_cin8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8 || busy8) pulses++;
        end
        chk("arst_nodone", 32'(pulses), 32'd0);
        p8_s = 0; p8_c = 0; p8_o = 0;
        p1_s = 0; p1_c = 0; p1_o = 0;
        add8(8'h01, 8'h01, 1'b0, -1);

        add1(1'b1, 1'b1, 1'b1);
        add1(1'b0, 1'b0, 1'b1);
        add1(1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++)
            add8(8'($urandom), 8'($urandom), 1'($urandom), -1);
        for (int i = 0; i < 1000; i++)
            add1(1'($urandom), 1'($urandom), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
